// File: rtl/fu_mem_load_sched.sv
// Load scheduler: in-order load queue feeding the memory FU, one load in flight, mispredict squash by ROB window.
// Latency: dispatch->issue 2 cycles into an idle empty queue; mem_done->writeback 1 cycle. Backpressure via ld_ready (count < DEPTH).
// Optional watchdog in WAIT enabled by LD_SCHED_TIMEOUT_EN (adds sticky timeout_err output).
module fu_mem_load_sched #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rob_index,
    input  logic [2:0]  ld_func3,
    input  logic [31:0] ld_imm,
    input  logic [31:0] ld_base,
    input  logic [6:0]  ld_pd,
    input  logic        mispredict,
    input  logic [4:0]  mispredict_tag,
    input  logic [4:0]  curr_rob_tag,
    output logic        mem_issued,
    output logic [4:0]  mem_rob_index,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_imm,
    output logic [31:0] mem_base,
    output logic [6:0]  mem_pd,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rob_index,
    output logic [6:0]  wb_pd,
    output logic [31:0] wb_data,
    output logic        busy
`ifdef LD_SCHED_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [DEPTH-1:0] q_vld;
    logic [4:0]    q_rob   [DEPTH];
    logic [2:0]    q_func3 [DEPTH];
    logic [31:0]   q_imm   [DEPTH];
    logic [31:0]   q_base  [DEPTH];
    logic [6:0]    q_pd    [DEPTH];

    logic [4:0]    inflight_rob;
    logic [6:0]    inflight_pd;
    logic          squashed;

    logic enq, pop, start, head_live, tmo_fire;

    // Tag t is younger than the branch and older than the ROB tail (exclusive of both ends).
    function automatic logic flush_hit(input logic [4:0] t);
        logic [4:0] d;
        logic [4:0] lim;
        d   = t - mispredict_tag;
        lim = curr_rob_tag - mispredict_tag;
        return mispredict && (d != 5'd0) && (d < lim);
    endfunction

    assign ld_ready  = (count < (AW+1)'(DEPTH));
    assign enq       = ld_valid && ld_ready;
    assign busy      = (state != IDLE) || (count != '0);
    assign head_live = q_vld[head] && !flush_hit(q_rob[head]);

`ifdef LD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_fire = (state == WAIT) && !mem_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt     <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
            timeout_err <= timeout_err | tmo_fire;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (head_live) begin
                        start     = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ISSUE: begin
                pop       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_done || tmo_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Squashed entries only lose their valid bit; they are retired when they reach head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_hit(q_rob[i])) q_vld[i] <= 1'b0;
            end
            if (enq) begin
                q_vld[tail] <= !flush_hit(ld_rob_index);
                tail        <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            count <= count + (AW+1)'(enq) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_rob[tail]   <= ld_rob_index;
            q_func3[tail] <= ld_func3;
            q_imm[tail]   <= ld_imm;
            q_base[tail]  <= ld_base;
            q_pd[tail]    <= ld_pd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mem_issued    <= 1'b0;
            mem_rob_index <= '0;
            mem_func3     <= '0;
            mem_imm       <= '0;
            mem_base      <= '0;
            mem_pd        <= '0;
            inflight_rob  <= '0;
            inflight_pd   <= '0;
            squashed      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rob_index  <= '0;
            wb_pd         <= '0;
            wb_data       <= '0;
        end else begin
            state      <= state_nxt;
            mem_issued <= start;
            wb_valid   <= 1'b0;
            if (start) begin
                mem_rob_index <= q_rob[head];
                mem_func3     <= q_func3[head];
                mem_imm       <= q_imm[head];
                mem_base      <= q_base[head];
                mem_pd        <= q_pd[head];
                inflight_rob  <= q_rob[head];
                inflight_pd   <= q_pd[head];
            end else begin
                mem_rob_index <= '0;
                mem_func3     <= '0;
                mem_imm       <= '0;
                mem_base      <= '0;
                mem_pd        <= '0;
            end
            if (state == ISSUE)
                squashed <= flush_hit(inflight_rob);
            else if (state == WAIT && flush_hit(inflight_rob))
                squashed <= 1'b1;
            // A mispredict landing with mem_done still kills the result.
            if (state == WAIT && mem_done && !squashed && !flush_hit(inflight_rob)) begin
                wb_valid     <= 1'b1;
                wb_data      <= mem_data;
                wb_rob_index <= inflight_rob;
                wb_pd        <= inflight_pd;
            end
        end
    end

endmodule

// File: tb/tb_fu_mem_load_sched.sv
// Scoreboard bench for fu_mem_load_sched: memory stub answers 3 cycles after each issue.
module tb_fu_mem_load_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rob_index;
    logic [2:0]  ld_func3;
    logic [31:0] ld_imm;
    logic [31:0] ld_base;
    logic [6:0]  ld_pd;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic [4:0]  curr_rob_tag;
    logic        mem_issued;
    logic [4:0]  mem_rob_index;
    logic [2:0]  mem_func3;
    logic [31:0] mem_imm;
    logic [31:0] mem_base;
    logic [6:0]  mem_pd;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        wb_valid;
    logic [4:0]  wb_rob_index;
    logic [6:0]  wb_pd;
    logic [31:0] wb_data;
    logic        busy;
`ifdef LD_SCHED_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    fu_mem_load_sched dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rob_index(ld_rob_index),
        .ld_func3(ld_func3), .ld_imm(ld_imm), .ld_base(ld_base), .ld_pd(ld_pd),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .curr_rob_tag(curr_rob_tag),
        .mem_issued(mem_issued), .mem_rob_index(mem_rob_index), .mem_func3(mem_func3),
        .mem_imm(mem_imm), .mem_base(mem_base), .mem_pd(mem_pd),
        .mem_done(mem_done), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_rob_index(wb_rob_index), .wb_pd(wb_pd), .wb_data(wb_data),
        .busy(busy)
`ifdef LD_SCHED_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        logic [4:0]  rob;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] base;
        logic [6:0]  pd;
        logic [31:0] data;
    } ld_t;

    ld_t exp_iss[$];
    ld_t exp_wb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int iss_n = 0, wb_n = 0, iss_cyc = 0, wb_cyc = 0;
    bit outstanding = 0;

    int          stub_cnt = 0;
    logic        stub_pulse = 1'b0;
    logic        manual_done = 1'b0;
    logic [31:0] stub_data = '0;

    assign mem_done = stub_pulse | manual_done;
    assign mem_data = stub_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor first (sees the stub's previous mem_done), then the memory stub update.
    always @(negedge clk) begin
        ld_t e;
        if (reset) begin
            outstanding = 0;
            stub_cnt    = 0;
            stub_pulse  = 1'b0;
        end else begin
            if (mem_done) outstanding = 0;
            if (mem_issued) begin
                chk("issue_overlap", 32'(outstanding), 32'd0);
                outstanding = 1;
                iss_n++;
                iss_cyc = cyc;
                if (exp_iss.size() == 0) chk("issue_unexpected", 32'(mem_rob_index), 32'hffffffff);
                else begin
                    e = exp_iss.pop_front();
                    chk("iss_rob",  32'(mem_rob_index), 32'(e.rob));
                    chk("iss_f3",   32'(mem_func3),     32'(e.f3));
                    chk("iss_imm",  mem_imm,            e.imm);
                    chk("iss_base", mem_base,           e.base);
                    chk("iss_pd",   32'(mem_pd),        32'(e.pd));
                end
            end
            if (wb_valid) begin
                wb_n++;
                wb_cyc = cyc;
                if (exp_wb.size() == 0) chk("wb_unexpected", 32'(wb_rob_index), 32'hffffffff);
                else begin
                    e = exp_wb.pop_front();
                    chk("wb_rob",  32'(wb_rob_index), 32'(e.rob));
                    chk("wb_pd",   32'(wb_pd),        32'(e.pd));
                    chk("wb_data", wb_data,           e.data);
                end
            end
            stub_pulse = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) stub_pulse = 1'b1;
            end
            if (mem_issued) begin
                stub_cnt  = 3;
                stub_data = 32'h44332211 + mem_base + mem_imm;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dispatch(input logic [4:0] rob, input logic [6:0] pd, input logic [31:0] base,
                            input logic [31:0] imm, input bit do_iss, input bit do_wb);
        ld_t e;
        int  b;
        b = 0;
        while (!ld_ready && b < 200) begin
            tick();
            b++;
        end
        if (!ld_ready) chk("dispatch_ready_timeout", 32'(ld_ready), 32'd1);
        e.rob  = rob;
        e.f3   = rob[0] ? 3'b100 : 3'b010;
        e.imm  = imm;
        e.base = base;
        e.pd   = pd;
        e.data = 32'h44332211 + base + imm;
        ld_valid = 1'b1; ld_rob_index = rob; ld_func3 = e.f3;
        ld_imm = imm; ld_base = base; ld_pd = pd;
        if (do_iss) exp_iss.push_back(e);
        if (do_wb)  exp_wb.push_back(e);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int b;
        b = 0;
        while ((busy || exp_iss.size() != 0 || exp_wb.size() != 0) && b < 400) begin
            tick();
            b++;
        end
        chk({tag, "_busy"},    32'(busy),           32'd0);
        chk({tag, "_iss_left"}, 32'(exp_iss.size()), 32'd0);
        chk({tag, "_wb_left"},  32'(exp_wb.size()),  32'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ld_ready"},   32'(ld_ready),      32'd1);
        chk({tag, "_busy"},       32'(busy),          32'd0);
        chk({tag, "_mem_issued"}, 32'(mem_issued),    32'd0);
        chk({tag, "_mem_rob"},    32'(mem_rob_index), 32'd0);
        chk({tag, "_mem_f3"},     32'(mem_func3),     32'd0);
        chk({tag, "_mem_imm"},    mem_imm,            32'd0);
        chk({tag, "_mem_base"},   mem_base,           32'd0);
        chk({tag, "_mem_pd"},     32'(mem_pd),        32'd0);
        chk({tag, "_wb_valid"},   32'(wb_valid),      32'd0);
        chk({tag, "_wb_rob"},     32'(wb_rob_index),  32'd0);
        chk({tag, "_wb_pd"},      32'(wb_pd),         32'd0);
        chk({tag, "_wb_data"},    wb_data,            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_disp, wb_before;
        reset = 1'b1; ld_valid = 1'b0; ld_rob_index = '0; ld_func3 = '0; ld_imm = '0;
        ld_base = '0; ld_pd = '0; mispredict = 1'b0; mispredict_tag = '0; curr_rob_tag = '0;
        tick(2);
        reset = 1'b0;
        tick();
        check_quiet("reset");

        // Single LW: issue at dispatch+2, result 3 cycles later, writeback 1 cycle after that.
        t_disp = cyc;
        dispatch(5'd1, 7'd10, 32'd0, 32'd0, 1, 1);
        drain("single");
        chk("single_issue_lat", 32'(iss_cyc - t_disp), 32'd2);
        chk("single_wb_lat",    32'(wb_cyc - iss_cyc), 32'd4);
        chk("single_iss_n",     32'(iss_n),            32'd1);
        chk("single_wb_n",      32'(wb_n),             32'd1);

        // Tag 0 in flight while tags 1..4 fill the queue.
        for (int i = 0; i < 5; i++)
            dispatch(5'(i), 7'(20 + i), 32'(i * 16), 32'd4, 1, 1);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_busy",     32'(busy),     32'd1);
        drain("fill");

        // Squash tags 4..7 (branch 3, tail 8): v=0 mispredict in ISSUE cycle with same-cycle enqueue, v=1 in WAIT.
        for (int v = 0; v < 2; v++) begin
            wb_before = wb_n;
            dispatch(5'd4, 7'd40, 32'h100, 32'h8, 1, 0);
            dispatch(5'd5, 7'd41, 32'h200, 32'h8, 0, 0);
            mispredict_tag = 5'd3; curr_rob_tag = 5'd8;
            if (v == 0) mispredict = 1'b1;
            dispatch(5'd6, 7'd42, 32'h300, 32'h8, 0, 0);
            mispredict = 1'b1;
            tick();
            mispredict = 1'b0;
            drain(v == 0 ? "squash_issue" : "squash_wait");
            chk("squash_no_wb", 32'(wb_n - wb_before), 32'd0);
        end

        // Branch itself in flight and a tag past the tail survive.
        dispatch(5'd5, 7'd50, 32'h40, 32'h0, 1, 1);
        dispatch(5'd9, 7'd51, 32'h80, 32'h4, 1, 1);
        mispredict_tag = 5'd5; curr_rob_tag = 5'd8; mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        drain("survive");

        // Wrapped window: branch 30, tail 2 kills 31 and 0 (0 enqueued in the flush cycle); 2 survives.
        dispatch(5'd30, 7'd60, 32'h1000, 32'h10, 1, 1);
        dispatch(5'd31, 7'd61, 32'h2000, 32'h10, 0, 0);
        mispredict_tag = 5'd30; curr_rob_tag = 5'd2; mispredict = 1'b1;
        dispatch(5'd0, 7'd62, 32'h3000, 32'h10, 0, 0);
        mispredict = 1'b0;
        dispatch(5'd2, 7'd63, 32'h4000, 32'h10, 1, 1);
        drain("wrap");

        // Reset while WAIT, then a stray mem_done.
        dispatch(5'd7, 7'd70, 32'h55, 32'h1, 1, 1);
        tick(2);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        exp_wb.delete();
        tick();
        reset = 1'b0;
        wb_before = wb_n;
        check_quiet("rst_mid");
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        tick(3);
        chk("rst_stray_wb", 32'(wb_n - wb_before), 32'd0);
        check_quiet("rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
